// File: rtl/input_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : input_deserializer
// Description : Packs bus beats (LSB chunk first) into one sample and offers
//               it to the core over valid/ready, pushing back upstream on stall.
// Revision    : 1.0 - initial release
// ============================================================================
module input_deserializer #(
    parameter int INPUT_SIZE_BITS = 784,
    parameter int INPUT_BUS_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inp_vld,
    input  logic [INPUT_BUS_WIDTH-1:0] inp,
    output logic                       stall,
    output logic                       sample_vld,
    input  logic                       sample_rdy,
    output logic [INPUT_SIZE_BITS-1:0] sample
);

    localparam int c_BEATS     = (INPUT_SIZE_BITS + INPUT_BUS_WIDTH - 1) / INPUT_BUS_WIDTH;
    localparam int c_LAST_BITS = INPUT_SIZE_BITS - INPUT_BUS_WIDTH * (c_BEATS - 1);
    localparam int c_CNT_W     = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    logic [c_CNT_W-1:0]         r_cnt;
    logic [INPUT_SIZE_BITS-1:0] r_asm;
    logic                       r_full;
    logic [INPUT_SIZE_BITS-1:0] r_out;
    logic                       r_vld;

    logic                       w_accept;
    logic                       w_last;
    logic                       w_slot_free;
    logic [INPUT_SIZE_BITS-1:0] w_asm_next;

    assign w_accept    = inp_vld && !r_full;
    assign w_last      = w_accept && (r_cnt == c_LAST_BEAT);
    assign w_slot_free = !r_vld || sample_rdy;

    // Only the low c_LAST_BITS of the final beat are real data; the rest is padding.
    always_comb begin
        w_asm_next = r_asm;
        for (int j = 0; j < c_BEATS - 1; j++) begin
            if (r_cnt == c_CNT_W'(j)) begin
                w_asm_next[j*INPUT_BUS_WIDTH +: INPUT_BUS_WIDTH] = inp;
            end
        end
        if (r_cnt == c_LAST_BEAT) begin
            w_asm_next[INPUT_BUS_WIDTH*(c_BEATS-1) +: c_LAST_BITS] = inp[c_LAST_BITS-1:0];
        end
    end

    generate
        if (c_LAST_BITS < INPUT_BUS_WIDTH) begin : g_pad
            logic w_pad_unused;
            assign w_pad_unused = ^inp[INPUT_BUS_WIDTH-1:c_LAST_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_asm  <= '0;
            r_full <= 1'b0;
            r_out  <= '0;
            r_vld  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm <= w_asm_next;
                r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
            end

            // r_full implies r_vld, so the slot always drains before the parked sample moves.
            if (w_last && w_slot_free) begin
                r_out <= w_asm_next;
                r_vld <= 1'b1;
            end else if (w_last) begin
                r_full <= 1'b1;
            end else if (r_full && sample_rdy) begin
                r_out  <= r_asm;
                r_full <= 1'b0;
            end else if (r_vld && sample_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign stall      = r_full;
    assign sample_vld = r_vld;
    assign sample     = r_out;

endmodule
`default_nettype wire
